fpu_arbiter: RTL and testbench

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_arb_pkg.sv | 52 +++++
 rtl/fpu_arbiter_rr_arbiter.sv | 43 ++++
 rtl/fpu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fpu_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types for the FPU arbiter slice.
//  - fpu_req_t   : request payload handed to the FPU (operands + op control)
//  - arb_state_e : arbiter FSM states (ARB, HOLD)
//  - id_w()      : width of the requester-index tag for a given requester count
// The operation-control field types keep the widths and encodings of fpnew_pkg.
// That lets the payload be bit-compatible with an fpnew FPU while this slice stays self-contained.
package fpu_arb_pkg;

    localparam int FP_WIDTH     = 64;
    localparam int NUM_OPERANDS = 3;

    typedef logic [2:0] roundmode_t;   // RNE/RTZ/RDN/RUP/RMM/ROD/DYN
    typedef logic [3:0] operation_t;   // FMADD .. CPKCD
    typedef logic [2:0] fp_format_t;   // FP32/FP64/FP16/FP8/FP16ALT
    typedef logic [1:0] int_format_t;  // INT8/INT16/INT32/INT64

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef struct packed {
        logic [NUM_OPERANDS-1:0][FP_WIDTH-1:0] operands;
        roundmode_t                            rnd_mode;
        operation_t                            op;
        logic                                  op_mod;
        fp_format_t                            src_fmt;
        fp_format_t                            dst_fmt;
        int_format_t                           int_fmt;
        logic                                  vectorial_op;
    } fpu_req_t;

    localparam int REQ_W = $bits(fpu_req_t);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Tag width: one bit minimum so a single-requester build still has a port.
    function automatic int id_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//  req_i   : request vector
//  ptr_i   : index of the last served requester; search starts at ptr_i+1
//  gnt_o   : one-hot grant (all zero when nothing requests)
//  idx_o   : index of the granted requester (ptr_i when nothing requests)
//  valid_o : some requester was picked
// NUM_REQ must be a power of two so the pointer arithmetic wraps naturally.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    logic [ID_W-1:0] cand_s;

    // Scan from lowest to highest priority; the last hit written is the winner.
    always_comb begin
        idx_o   = ptr_i;
        valid_o = 1'b0;
        cand_s  = ptr_i;
        for (int k = NUM_REQ; k > 0; k--) begin
            cand_s = ptr_i + ID_W'(k);
            if (req_i[cand_s]) begin
                idx_o   = cand_s;
                valid_o = 1'b1;
            end else begin
                idx_o   = idx_o;
                valid_o = valid_o;
            end
        end
        if (valid_o) begin
            gnt_o = NUM_REQ'(1'b1) << idx_o;
        end else begin
            gnt_o = {NUM_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU between NUM_REQ requesters.
// Request side  : round-robin grant, locked in HOLD while the FPU back-pressures;
//                 the request path is combinational (no added latency).
// Response side : routed to the requester named by the returned tag.
// Flow control  : at most MAX_OUTSTANDING requests in flight inside the FPU.
// Ports:
//  clk_i, rst_ni                          clock, async active-low reset
//  req_valid_i/req_ready_o/req_data_i     per-requester request handshake + payload
//  rsp_valid_o/rsp_ready_i                per-requester response handshake
//  rsp_result_o/rsp_status_o              shared response data
//  fpu_in_valid_o/fpu_in_ready_i          FPU request handshake
//  fpu_req_o/fpu_tag_o                    FPU request payload + requester tag
//  fpu_out_valid_i/fpu_out_ready_o        FPU response handshake
//  fpu_result_i/fpu_status_i/fpu_tag_i    FPU response payload + tag
//  flush_i/fpu_flush_o                    flush, forwarded to the FPU
//  fpu_busy_i/busy_o                      FPU busy in, arbiter busy out
module fpu_arbiter import fpu_arb_pkg::*; #(
    parameter  int NUM_REQ         = 2,
    parameter  int WIDTH           = 64,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int ID_W            = id_w(NUM_REQ),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0][REQ_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    input  logic [NUM_REQ-1:0]              rsp_ready_i,
    output logic [WIDTH-1:0]                rsp_result_o,
    output logic [4:0]                      rsp_status_o,
    output logic                            fpu_in_valid_o,
    input  logic                            fpu_in_ready_i,
    output logic [REQ_W-1:0]                fpu_req_o,
    output logic [ID_W-1:0]                 fpu_tag_o,
    input  logic                            fpu_out_valid_i,
    output logic                            fpu_out_ready_o,
    input  logic [WIDTH-1:0]                fpu_result_i,
    input  logic [4:0]                      fpu_status_i,
    input  logic [ID_W-1:0]                 fpu_tag_i,
    input  logic                            flush_i,
    output logic                            fpu_flush_o,
    input  logic                            fpu_busy_i,
    output logic                            busy_o
);

    arb_state_e          state_r;
    arb_state_e          state_nxt_s;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     hold_idx_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;

    logic [NUM_REQ-1:0]  rr_gnt_s;
    logic [ID_W-1:0]     rr_idx_s;
    logic                rr_valid_s;

    logic [NUM_REQ-1:0]  gnt_vec_s;
    logic [ID_W-1:0]     gnt_idx_s;
    logic                gnt_valid_s;
    logic                room_s;
    logic                in_valid_s;
    logic                accept_s;
    logic                out_ready_s;
    logic                rsp_hs_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_r),
        .gnt_o   (rr_gnt_s),
        .idx_o   (rr_idx_s),
        .valid_o (rr_valid_s)
    );

    // Grant selection: fresh round-robin pick in ARB, locked requester in HOLD.
    always_comb begin
        if (state_r == HOLD) begin
            gnt_idx_s   = hold_idx_r;
            gnt_vec_s   = NUM_REQ'(1'b1) << hold_idx_r;
            gnt_valid_s = req_valid_i[hold_idx_r];
        end else begin
            gnt_idx_s   = rr_idx_s;
            gnt_vec_s   = rr_gnt_s;
            gnt_valid_s = rr_valid_s;
        end
    end

    // Request and response handshakes; everything is forced quiet while reset is held.
    always_comb begin
        room_s     = (cnt_r < CNT_W'(MAX_OUTSTANDING));
        in_valid_s = gnt_valid_s & room_s & ~flush_i & rst_ni;
        accept_s   = in_valid_s & fpu_in_ready_i;
        if (flush_i) begin
            out_ready_s = rst_ni;   // drain whatever the FPU is still returning
        end else begin
            out_ready_s = rsp_ready_i[fpu_tag_i] & rst_ni;
        end
        rsp_hs_s = fpu_out_valid_i & out_ready_s;

        fpu_in_valid_o  = in_valid_s;
        fpu_req_o       = req_data_i[gnt_idx_s];
        fpu_tag_o       = gnt_idx_s;
        fpu_out_ready_o = out_ready_s;
        fpu_flush_o     = flush_i;
        rsp_result_o    = fpu_result_i;
        rsp_status_o    = fpu_status_i;
        if (accept_s) begin
            req_ready_o = gnt_vec_s;
        end else begin
            req_ready_o = {NUM_REQ{1'b0}};
        end
        if (fpu_out_valid_i && !flush_i && rst_ni) begin
            rsp_valid_o = NUM_REQ'(1'b1) << fpu_tag_i;
        end else begin
            rsp_valid_o = {NUM_REQ{1'b0}};
        end
        busy_o = (cnt_r != {CNT_W{1'b0}}) | (state_r == HOLD) | fpu_busy_i;
    end

    // FSM next state: lock the grant while the FPU refuses it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB: begin
                if (in_valid_s && !fpu_in_ready_i) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = ARB;
                end
            end
            HOLD: begin
                if (accept_s || flush_i) begin
                    state_nxt_s = ARB;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = ARB;
        endcase
    end

    // Outstanding count: accept and response in the same cycle cancel out;
    // a response with nothing outstanding (e.g. left over from before reset) is ignored.
    always_comb begin
        if (flush_i) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (accept_s && !rsp_hs_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else if (rsp_hs_s && !accept_s && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers; ptr resets to the last index so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ARB;
            ptr_r      <= ID_W'(NUM_REQ - 1);
            hold_idx_r <= {ID_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                ptr_r <= gnt_idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
            if (state_r == ARB) begin
                hold_idx_r <= rr_idx_s;
            end else begin
                hold_idx_r <= hold_idx_r;
            end
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
module tb_fpu_arbiter;
    import fpu_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 64;
    localparam int MAXO    = 4;
    localparam int IDW     = 1;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [NUM_REQ-1:0]             req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NUM_REQ-1:0][REQ_W-1:0]  req_data;
    logic [WIDTH-1:0]               rsp_result, fpu_result;
    logic [4:0]                     rsp_status, fpu_status;
    logic                           fpu_in_valid, fpu_in_ready, fpu_out_valid, fpu_out_ready;
    logic [REQ_W-1:0]               fpu_req;
    logic [IDW-1:0]                 fpu_tag, fpu_tag_in;
    logic                           flush, fpu_flush, fpu_busy, busy;

    int n_vec = 0;
    int n_err = 0;

    // model state: last accepted requester, requests in flight, locked requester (-1 none)
    int m_last = NUM_REQ - 1;
    int m_cnt  = 0;
    int m_lock = -1;

    fpu_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
        .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
        .fpu_req_o(fpu_req), .fpu_tag_o(fpu_tag),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
        .flush_i(flush), .fpu_flush_o(fpu_flush),
        .fpu_busy_i(fpu_busy), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // advance to just after the next rising edge, with fresh response payload
    task automatic nxt();
        @(posedge clk);
        #1;
        fpu_result = {$urandom, $urandom};
        fpu_status = 5'($urandom);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Behavioural model compare, every falling edge
    always @(negedge clk) begin : compare
        int win;
        int c;
        bit iv, acc, hs, e_or, e_busy;
        logic [NUM_REQ-1:0] e_rr, e_rv;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 2'b00);
            chk("rst_in_valid", fpu_in_valid, 1'b0);
            chk("rst_rsp_valid", rsp_valid, 2'b00);
            chk("rst_out_ready", fpu_out_ready, 1'b0);
            chk("rst_flush", fpu_flush, flush);
            chk("rst_busy", busy, fpu_busy);
            m_last = NUM_REQ - 1;
            m_cnt  = 0;
            m_lock = -1;
        end else begin
            win = -1;
            if (m_lock >= 0) begin
                if (req_valid[m_lock]) win = m_lock;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_last + k) % NUM_REQ;
                    if (win < 0 && req_valid[c]) win = c;
                end
            end
            iv  = (win >= 0) && (m_cnt < MAXO) && !flush;
            acc = iv && fpu_in_ready;
            e_rr = '0;
            if (acc) e_rr[win] = 1'b1;
            e_rv = '0;
            if (fpu_out_valid && !flush) e_rv[fpu_tag_in] = 1'b1;
            e_or = flush ? 1'b1 : rsp_ready[fpu_tag_in];
            hs   = fpu_out_valid && e_or;
            e_busy = (m_cnt != 0) || (m_lock >= 0) || fpu_busy;

            chk("m_in_valid", fpu_in_valid, iv);
            chk("m_req_ready", req_ready, e_rr);
            chk("m_rsp_valid", rsp_valid, e_rv);
            chk("m_out_ready", fpu_out_ready, e_or);
            chk("m_busy", busy, e_busy);
            chk("m_flush", fpu_flush, flush);
            chk("m_result", rsp_result, fpu_result);
            chk("m_status", rsp_status, fpu_status);
            if (iv) begin
                chk("m_tag", fpu_tag, win);
                chk("m_req", fpu_req, req_data[win]);
            end

            if (flush) begin
                m_cnt  = 0;
                m_lock = -1;
            end else begin
                if (acc) begin
                    m_last = win;
                    m_lock = -1;
                end else if (iv) begin
                    m_lock = win;
                end
                if (acc && !hs) m_cnt++;
                else if (hs && !acc && m_cnt > 0) m_cnt--;
            end
        end
    end

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; fpu_in_ready = 1'b0;
        fpu_out_valid = 1'b0; fpu_tag_in = 1'b0; flush = 1'b0; fpu_busy = 1'b0;
        fpu_result = 64'h0; fpu_status = 5'h0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int b = 0; b < REQ_W; b++) req_data[i][b] = 1'($urandom_range(0, 1));

        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        mid(); chk("post_rst_busy", busy, 1'b0); chk("post_rst_in_valid", fpu_in_valid, 1'b0);

        // Both requesters valid, responses one cycle later: 0,1,0,1
        nxt(); req_valid = 2'b11; fpu_in_ready = 1'b1; rsp_ready = 2'b11;
        mid(); chk("alt1_tag", fpu_tag, 1'b0); chk("alt1_rdy", req_ready, 2'b01);
        nxt(); fpu_out_valid = 1'b1; fpu_tag_in = 1'b0;
        mid(); chk("alt2_tag", fpu_tag, 1'b1); chk("alt2_rdy", req_ready, 2'b10); chk("alt2_rsp", rsp_valid, 2'b01);
        nxt(); fpu_tag_in = 1'b1;
        mid(); chk("alt3_tag", fpu_tag, 1'b0); chk("alt3_rdy", req_ready, 2'b01); chk("alt3_rsp", rsp_valid, 2'b10);
        nxt(); fpu_tag_in = 1'b0;
        mid(); chk("alt4_tag", fpu_tag, 1'b1); chk("alt4_rdy", req_ready, 2'b10);
        nxt(); req_valid = 2'b00; fpu_tag_in = 1'b1;
        mid(); chk("alt5_rdy", req_ready, 2'b00); chk("alt5_rsp", rsp_valid, 2'b10);
        nxt(); fpu_out_valid = 1'b0;
        mid(); chk("alt_idle_busy", busy, 1'b0);

        // HOLD: requester 1 locked for 3 back-pressured cycles, requester 0 joins
        nxt(); req_valid = 2'b10; fpu_in_ready = 1'b0;
        mid(); chk("hold1_tag", fpu_tag, 1'b1); chk("hold1_vld", fpu_in_valid, 1'b1); chk("hold1_rdy", req_ready, 2'b00);
        for (int i = 2; i <= 3; i++) begin
            nxt(); req_valid = 2'b11;
            mid(); chk("hold_tag", fpu_tag, 1'b1); chk("hold_req", fpu_req, req_data[1]);
            chk("hold_rdy", req_ready, 2'b00); chk("hold_busy", busy, 1'b1);
        end
        nxt(); fpu_in_ready = 1'b1;
        mid(); chk("hold4_tag", fpu_tag, 1'b1); chk("hold4_rdy", req_ready, 2'b10);
        nxt();
        mid(); chk("hold5_tag", fpu_tag, 1'b0); chk("hold5_rdy", req_ready, 2'b01);
        nxt(); req_valid = 2'b00; fpu_out_valid = 1'b1; fpu_tag_in = 1'b1;
        nxt(); fpu_tag_in = 1'b0;
        nxt(); fpu_out_valid = 1'b0;
        mid(); chk("hold_drain_busy", busy, 1'b0);

        // Outstanding limit: 4 accepts, 5th stalled until one response
        nxt(); req_valid = 2'b01; fpu_in_ready = 1'b1; rsp_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            mid(); chk("lim_rdy", req_ready, 2'b01);
            nxt();
        end
        mid(); chk("lim_stall_vld", fpu_in_valid, 1'b0); chk("lim_stall_busy", busy, 1'b1);
        nxt(); fpu_out_valid = 1'b1; fpu_tag_in = 1'b0;
        mid(); chk("lim_rsp_vld", fpu_in_valid, 1'b0); chk("lim_rsp", rsp_valid, 2'b01);
        nxt(); fpu_out_valid = 1'b0;
        mid(); chk("lim_5th_rdy", req_ready, 2'b01);
        nxt();
        mid(); chk("lim_full_again", fpu_in_valid, 1'b0);

        // Response routing with the owner not ready, then ready
        nxt(); req_valid = 2'b00; fpu_out_valid = 1'b1; fpu_tag_in = 1'b1; rsp_ready = 2'b01;
        mid(); chk("route_vld", rsp_valid, 2'b10); chk("route_nrdy", fpu_out_ready, 1'b0);
        nxt(); rsp_ready = 2'b10;
        mid(); chk("route_rdy", fpu_out_ready, 1'b1);
        nxt(); fpu_out_valid = 1'b0; req_valid = 2'b01;
        mid(); chk("route_dec_acc", req_ready, 2'b01);
        nxt();
        mid(); chk("route_full", fpu_in_valid, 1'b0);

        // Flush in HOLD with 3 in flight
        nxt(); req_valid = 2'b00; fpu_out_valid = 1'b1; fpu_tag_in = 1'b0; rsp_ready = 2'b01;
        nxt(); fpu_out_valid = 1'b0; req_valid = 2'b10; fpu_in_ready = 1'b0;
        mid(); chk("fl_hold_tag", fpu_tag, 1'b1);
        nxt(); flush = 1'b1; fpu_in_ready = 1'b1; fpu_out_valid = 1'b1; rsp_ready = 2'b00;
        mid(); chk("fl_fwd", fpu_flush, 1'b1); chk("fl_vld", fpu_in_valid, 1'b0);
        chk("fl_rdy", req_ready, 2'b00); chk("fl_rsp", rsp_valid, 2'b00); chk("fl_drain", fpu_out_ready, 1'b1);
        nxt(); flush = 1'b0; fpu_out_valid = 1'b0; req_valid = 2'b00;
        mid(); chk("fl_after_busy", busy, 1'b0);

        // Async reset in HOLD with 2 in flight
        nxt(); req_valid = 2'b01; fpu_in_ready = 1'b1;
        nxt();
        nxt(); req_valid = 2'b11; fpu_in_ready = 1'b0;
        mid(); chk("ar_hold_tag", fpu_tag, 1'b1);
        nxt(); fpu_out_valid = 1'b1; fpu_tag_in = 1'b1; rsp_ready = 2'b11;
        #2; rst_n = 1'b0;
        #1;
        chk("ar_rdy", req_ready, 2'b00); chk("ar_vld", fpu_in_valid, 1'b0);
        chk("ar_rsp", rsp_valid, 2'b00); chk("ar_ordy", fpu_out_ready, 1'b0); chk("ar_busy", busy, 1'b0);
        nxt(); rst_n = 1'b1; req_valid = 2'b00;
        mid(); chk("stray_rsp", rsp_valid, 2'b10); chk("stray_ordy", fpu_out_ready, 1'b1);
        nxt(); fpu_out_valid = 1'b0; req_valid = 2'b11; fpu_in_ready = 1'b1;
        mid(); chk("ar_first_tag", fpu_tag, 1'b0); chk("ar_first_rdy", req_ready, 2'b01);
        nxt(); req_valid = 2'b00; fpu_busy = 1'b1;
        mid(); chk("fpu_busy", busy, 1'b1);
        nxt(); fpu_busy = 1'b0; fpu_out_valid = 1'b1; fpu_tag_in = 1'b0;
        nxt(); fpu_out_valid = 1'b0;
        mid(); chk("end_busy", busy, 1'b0);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
